ow_rom_ctrl: RTL and testbench

1-Wire slave ROM-command controller. Sits between the bit-level slot decoder/encoder and the `s2p` 64-bit deserializer, and sequences a slave transaction. It handles bus reset and presence, decodes the ROM command byte, and serves Read ROM by shifting out the device ID. It drives `s2p` for Match ROM and compares the assembled frame against the ID. Once selected, it delivers the function-command byte to the application layer.

---
 rtl/ow_pkg.sv | 23 ++
 rtl/ow_rom_ctrl_if.sv | 33 +++
 rtl/ow_byte_rx.sv | 45 ++++
 rtl/ow_rom_ctrl.sv | 141 ++++++++++++++
 tb/tb_ow_rom_ctrl.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ow_pkg.sv
// Shared types and constants for the 1-Wire slave ROM-command controller.
package ow_pkg;

  localparam int FRAME_W = 64;

  localparam logic [7:0] CMD_READ_ROM   = 8'h33;
  localparam logic [7:0] CMD_MATCH_ROM  = 8'h55;
  localparam logic [7:0] CMD_SKIP_ROM   = 8'hCC;
  localparam logic [7:0] CMD_SEARCH_ROM = 8'hF0;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_PRESENCE,
    ST_ROM_CMD,
    ST_READ_ROM,
    ST_MATCH,
    ST_MATCH_CHK,
    ST_FUNC_CMD,
    ST_SELECTED,
    ST_DESELECTED
  } ow_state_e;

endpackage

// File: rtl/ow_rom_ctrl_if.sv
// Bit-slot, s2p, transmit and function-command signals of the ROM controller.
interface ow_rom_ctrl_if;
  import ow_pkg::*;

  logic               i_bus_reset;
  logic               i_bit_val;
  logic               i_bit_ready;
  logic               o_presence;
  logic               o_s2p_rst;
  logic               o_s2p_bit_val;
  logic               o_s2p_bit_ready;
  logic [FRAME_W-1:0] i_frame;
  logic               i_frame_ready;
  logic               o_tx_bit;
  logic               o_tx_valid;
  logic               i_tx_ready;
  logic               o_selected;
  logic [7:0]         o_func_cmd;
  logic               o_func_valid;

  modport slave (
    input  i_bus_reset, i_bit_val, i_bit_ready, i_frame, i_frame_ready, i_tx_ready,
    output o_presence, o_s2p_rst, o_s2p_bit_val, o_s2p_bit_ready,
           o_tx_bit, o_tx_valid, o_selected, o_func_cmd, o_func_valid
  );

  modport master (
    output i_bus_reset, i_bit_val, i_bit_ready, i_frame, i_frame_ready, i_tx_ready,
    input  o_presence, o_s2p_rst, o_s2p_bit_val, o_s2p_bit_ready,
           o_tx_bit, o_tx_valid, o_selected, o_func_cmd, o_func_valid
  );

endinterface

// File: rtl/ow_byte_rx.sv
// LSB-first 8-bit collector; last/byte_nxt let the FSM decode in the same cycle
// as the 8th strobe, byte_q/done hold the latched byte for the application.
module ow_byte_rx (
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       strobe,
  input  logic       bit_val,
  input  logic       latch,
  output logic [7:0] byte_nxt,
  output logic       last,
  output logic [7:0] byte_q,
  output logic       done
);

  logic [6:0] sh;
  logic [2:0] cnt;

  assign byte_nxt = {bit_val, sh};
  assign last     = strobe && (cnt == 3'd7);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sh     <= '0;
      cnt    <= '0;
      byte_q <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (clr) begin
        sh  <= '0;
        cnt <= '0;
      end else if (strobe) begin
        sh  <= byte_nxt[7:1];
        cnt <= cnt + 3'd1;
      end
      // byte_q only tracks latched bytes so it holds across later ROM commands
      if (last && latch) begin
        byte_q <= byte_nxt;
        done   <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/ow_rom_ctrl.sv
// 1-Wire slave ROM-command sequencer: presence, ROM command decode, Read/Match/Skip ROM,
// then function-command delivery.
//
// state         | meaning
// --------------+-----------------------------------------------------------
// ST_IDLE       | after reset, waiting for the first bus reset
// ST_PRESENCE   | one cycle: request presence pulse, clear s2p
// ST_ROM_CMD    | collecting the ROM command byte
// ST_READ_ROM   | shifting ROM_ID out LSB first through the transmit handshake
// ST_MATCH      | forwarding 64 received bits to s2p
// ST_MATCH_CHK  | waiting for the s2p frame and comparing it with ROM_ID
// ST_FUNC_CMD   | collecting the function command byte
// ST_SELECTED   | addressed, idle until next bus reset
// ST_DESELECTED | not addressed, idle until next bus reset
module ow_rom_ctrl
  import ow_pkg::*;
#(
  parameter logic [FRAME_W-1:0] ROM_ID = 64'h5A00_0000_0012_3428
) (
  input  logic          clk,
  input  logic          reset,
  ow_rom_ctrl_if.slave  bus
);

  ow_state_e  state, state_nxt;
  logic [6:0] cnt;
  logic       cnt_inc;
  logic       entry;
  logic       sel_q;
  logic       set_sel;
  logic       rx_strobe;
  logic       rx_last;
  logic [7:0] rx_byte_nxt;
  logic [7:0] func_byte;
  logic       func_done;
  logic       tx_xfer;
  logic       fwd;

  assign rx_strobe = bus.i_bit_ready && !bus.i_bus_reset &&
                     ((state == ST_ROM_CMD) || (state == ST_FUNC_CMD));
  assign tx_xfer   = (state == ST_READ_ROM) && bus.i_tx_ready && !bus.i_bus_reset;
  assign fwd       = (state == ST_MATCH) && bus.i_bit_ready && !bus.i_bus_reset;
  assign entry     = (state_nxt != state) || bus.i_bus_reset;

  ow_byte_rx u_byte_rx (
    .clk      (clk),
    .reset    (reset),
    .clr      (entry),
    .strobe   (rx_strobe),
    .bit_val  (bus.i_bit_val),
    .latch    (state == ST_FUNC_CMD),
    .byte_nxt (rx_byte_nxt),
    .last     (rx_last),
    .byte_q   (func_byte),
    .done     (func_done)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
      sel_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (entry)
        cnt <= '0;
      else if (cnt_inc)
        cnt <= cnt + 7'd1;
      if (bus.i_bus_reset)
        sel_q <= 1'b0;
      else if (set_sel)
        sel_q <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    set_sel   = 1'b0;
    cnt_inc   = 1'b0;
    if (bus.i_bus_reset) begin
      state_nxt = ST_PRESENCE;
    end else begin
      case (state)
        ST_PRESENCE: state_nxt = ST_ROM_CMD;
        ST_ROM_CMD: begin
          if (rx_last) begin
            case (rx_byte_nxt)
              CMD_READ_ROM:   state_nxt = ST_READ_ROM;
              CMD_MATCH_ROM:  state_nxt = ST_MATCH;
              CMD_SKIP_ROM: begin
                state_nxt = ST_FUNC_CMD;
                set_sel   = 1'b1;
              end
              CMD_SEARCH_ROM: state_nxt = ST_DESELECTED;
              default:        state_nxt = ST_DESELECTED;
            endcase
          end
        end
        ST_READ_ROM: begin
          if (tx_xfer) begin
            cnt_inc = 1'b1;
            if (cnt == 7'd63) begin
              set_sel   = 1'b1;
              state_nxt = ST_FUNC_CMD;
            end
          end
        end
        ST_MATCH: begin
          if (fwd) begin
            cnt_inc = 1'b1;
            if (cnt == 7'd63)
              state_nxt = ST_MATCH_CHK;
          end
        end
        ST_MATCH_CHK: begin
          if (bus.i_frame_ready) begin
            if (bus.i_frame == ROM_ID) begin
              set_sel   = 1'b1;
              state_nxt = ST_FUNC_CMD;
            end else begin
              state_nxt = ST_DESELECTED;
            end
          end
        end
        ST_FUNC_CMD: if (rx_last) state_nxt = ST_SELECTED;
        default: state_nxt = state;
      endcase
    end
  end

  assign bus.o_presence      = (state == ST_PRESENCE);
  assign bus.o_s2p_rst       = (state == ST_PRESENCE);
  assign bus.o_s2p_bit_val   = (state == ST_MATCH) && bus.i_bit_val;
  assign bus.o_s2p_bit_ready = fwd;
  assign bus.o_tx_valid      = (state == ST_READ_ROM);
  assign bus.o_tx_bit        = (state == ST_READ_ROM) && ROM_ID[cnt[5:0]];
  assign bus.o_selected      = sel_q;
  assign bus.o_func_cmd      = func_byte;
  assign bus.o_func_valid    = func_done;

endmodule

// File: tb/tb_ow_rom_ctrl.sv
// Directed and randomized transactions for ow_rom_ctrl against a transaction-level model.
module tb_ow_rom_ctrl;
  import ow_pkg::*;

  localparam logic [63:0] ID = 64'h5A00_0000_0012_3428;

  logic clk = 1'b0;
  logic reset = 1'b1;
  ow_rom_ctrl_if bus ();

  ow_rom_ctrl #(.ROM_ID(ID)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // observation counters, written only by the monitor
  int   n_pres = 0, n_s2prst = 0, n_fv = 0, n_fwd = 0, n_act = 0;
  logic tx_q[$];

  always @(negedge clk) begin
    if (!reset) begin
      if (bus.o_presence) n_pres++;
      if (bus.o_s2p_rst) n_s2prst++;
      if (bus.o_func_valid) n_fv++;
      if (bus.o_s2p_bit_ready) n_fwd++;
      if (bus.o_tx_valid && bus.i_tx_ready) tx_q.push_back(bus.o_tx_bit);
      if (bus.o_presence || bus.o_s2p_rst || bus.o_s2p_bit_ready || bus.o_tx_valid ||
          bus.o_func_valid || bus.o_selected) n_act++;
    end
  end

  // external s2p deserializer stand-in
  logic [63:0] s2p_sh;
  int          s2p_cnt;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      s2p_sh = '0;
      s2p_cnt = 0;
      bus.i_frame <= '0;
      bus.i_frame_ready <= 1'b0;
    end else begin
      bus.i_frame_ready <= 1'b0;
      if (bus.o_s2p_rst) begin
        s2p_sh = '0;
        s2p_cnt = 0;
      end else if (bus.o_s2p_bit_ready) begin
        s2p_sh = {bus.o_s2p_bit_val, s2p_sh[63:1]};
        s2p_cnt++;
        if (s2p_cnt == 64) begin
          bus.i_frame <= s2p_sh;
          bus.i_frame_ready <= 1'b1;
          s2p_cnt = 0;
        end
      end
    end
  end

  // reference: which command/frame combinations address the device
  function automatic bit exp_selected(input logic [7:0] cmd, input logic [63:0] frame);
    return (cmd == 8'hCC) || (cmd == 8'h33) || (cmd == 8'h55 && frame == ID);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    repeat ($urandom_range(0, 2)) tick();
    bus.i_bit_val = b;
    bus.i_bit_ready = 1'b1;
    tick();
    bus.i_bit_ready = 1'b0;
    bus.i_bit_val = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 0; i < 8; i++) send_bit(v[i]);
  endtask

  task automatic send_frame(input logic [63:0] f);
    for (int i = 0; i < 64; i++) send_bit(f[i]);
  endtask

  task automatic bus_reset_pulse();
    bus.i_bus_reset = 1'b1;
    tick();
    bus.i_bus_reset = 1'b0;
    tick();
  endtask

  // serve Read ROM until 64 bits transferred; rnd stalls i_tx_ready randomly
  task automatic read_rom(input string tag, input bit rnd);
    int q0, n;
    logic [63:0] got;
    q0 = tx_q.size();
    n = 0;
    while ((tx_q.size() - q0) < 64 && n < 500) begin
      bus.i_tx_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      tick();
      n++;
    end
    bus.i_tx_ready = 1'b0;
    chk({tag, "_count"}, 64'(tx_q.size() - q0), 64'd64);
    got = '0;
    for (int i = 0; i < 64 && (q0 + i) < tx_q.size(); i++) got[i] = tx_q[q0 + i];
    chk({tag, "_id"}, got, ID);
  endtask

  logic [7:0]  exp_fc;
  logic [7:0]  cmd, fb;
  logic [63:0] frame;
  int          f0, a0;
  bit          es;

  initial begin
    bus.i_bus_reset = 1'b0;
    bus.i_bit_val = 1'b0;
    bus.i_bit_ready = 1'b0;
    bus.i_tx_ready = 1'b0;
    exp_fc = 8'h00;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    @(negedge clk);
    chk("reset_outputs", {bus.o_presence, bus.o_s2p_rst, bus.o_s2p_bit_val, bus.o_s2p_bit_ready,
                          bus.o_tx_bit, bus.o_tx_valid, bus.o_selected, bus.o_func_valid}, 0);
    chk("reset_func_cmd", bus.o_func_cmd, 8'h00);

    // bits in IDLE are ignored
    tick();
    send_byte(8'hCC);
    tick();
    chk("idle_activity", 64'(n_act), 0);

    // bus reset -> one-cycle presence and s2p clear
    bus.i_bus_reset = 1'b1;
    tick();
    bus.i_bus_reset = 1'b0;
    @(negedge clk);
    chk("presence_hi", bus.o_presence, 1);
    chk("s2p_rst_hi", bus.o_s2p_rst, 1);
    chk("presence_others", {bus.o_tx_valid, bus.o_selected, bus.o_func_valid, bus.o_s2p_bit_ready}, 0);
    tick();
    @(negedge clk);
    chk("presence_lo", {bus.o_presence, bus.o_s2p_rst}, 0);
    chk("presence_count", 64'(n_pres), 1);
    tick();

    // Skip ROM + function byte
    send_byte(8'hCC);
    @(negedge clk);
    chk("skip_selected", bus.o_selected, 1);
    f0 = n_fv;
    send_byte(8'h44);
    @(negedge clk);
    chk("skip_fv_pulse", bus.o_func_valid, 1);
    chk("skip_fc", bus.o_func_cmd, 8'h44);
    exp_fc = 8'h44;
    tick();
    @(negedge clk);
    chk("skip_fv_once", 64'(n_fv - f0), 1);
    tick();

    // Read ROM
    bus_reset_pulse();
    chk("read_sel_cleared", bus.o_selected, 0);
    send_byte(8'h33);
    @(negedge clk);
    chk("read_tx_valid", bus.o_tx_valid, 1);
    chk("read_first_bit", bus.o_tx_bit, ID[0]);
    tick();
    read_rom("read", 1'b0);
    @(negedge clk);
    chk("read_selected", bus.o_selected, 1);
    chk("read_tx_done", bus.o_tx_valid, 0);
    tick();

    // Match ROM, correct ID
    bus_reset_pulse();
    send_byte(8'h55);
    send_frame(ID);
    repeat (3) tick();
    chk("match_selected", bus.o_selected, 1);
    f0 = n_fv;
    send_byte(8'hBE);
    tick();
    chk("match_fv", 64'(n_fv - f0), 1);
    chk("match_fc", bus.o_func_cmd, 8'hBE);
    exp_fc = 8'hBE;

    // Match ROM, bit 40 flipped
    bus_reset_pulse();
    send_byte(8'h55);
    send_frame(ID ^ (64'h1 << 40));
    repeat (3) tick();
    chk("mismatch_selected", bus.o_selected, 0);
    f0 = n_fv;
    send_byte(8'hBE);
    tick();
    chk("mismatch_no_fv", 64'(n_fv - f0), 0);
    chk("mismatch_fc_hold", bus.o_func_cmd, exp_fc);

    // bus reset colliding with bit 31 of a Match
    bus_reset_pulse();
    send_byte(8'h55);
    for (int i = 0; i < 30; i++) send_bit(ID[i]);
    f0 = n_fwd;
    bus.i_bus_reset = 1'b1;
    bus.i_bit_ready = 1'b1;
    bus.i_bit_val = ID[30];
    @(negedge clk);
    chk("midreset_no_fwd", bus.o_s2p_bit_ready, 0);
    tick();
    bus.i_bus_reset = 1'b0;
    bus.i_bit_ready = 1'b0;
    bus.i_bit_val = 1'b0;
    @(negedge clk);
    chk("midreset_presence", bus.o_presence, 1);
    chk("midreset_fwd_count", 64'(n_fwd - f0), 0);
    tick();
    send_byte(8'hCC);
    f0 = n_fv;
    send_byte(8'h5A);
    tick();
    chk("midreset_skip_sel", bus.o_selected, 1);
    chk("midreset_skip_fv", 64'(n_fv - f0), 1);
    chk("midreset_skip_fc", bus.o_func_cmd, 8'h5A);
    exp_fc = 8'h5A;

    // unsupported Search ROM
    bus_reset_pulse();
    send_byte(8'hF0);
    a0 = n_act;
    for (int i = 0; i < 16; i++) send_bit(1'($urandom_range(0, 1)));
    repeat (2) tick();
    chk("unknown_activity", 64'(n_act - a0), 0);
    chk("unknown_fc_hold", bus.o_func_cmd, exp_fc);

    // randomized transactions
    for (int t = 0; t < 12; t++) begin
      case ($urandom_range(0, 3))
        0: cmd = 8'h33;
        1: cmd = 8'h55;
        2: cmd = 8'hCC;
        default: cmd = 8'($urandom);
      endcase
      frame = ($urandom_range(0, 1) != 0) ? ID : (ID ^ (64'h1 << $urandom_range(0, 63)));
      fb = 8'($urandom);
      es = exp_selected(cmd, frame);
      bus_reset_pulse();
      send_byte(cmd);
      if (cmd == 8'h33) read_rom("rnd_read", 1'b1);
      if (cmd == 8'h55) begin
        send_frame(frame);
        repeat (3) tick();
      end
      f0 = n_fv;
      send_byte(fb);
      tick();
      if (es) exp_fc = fb;
      chk("rnd_selected", bus.o_selected, es);
      chk("rnd_fv", 64'(n_fv - f0), es ? 64'd1 : 64'd0);
      chk("rnd_fc", bus.o_func_cmd, exp_fc);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
